// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - LED pattern sequencer driven from a shared millisecond time base
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cfg_valid/cfg_ready config handshake; a word is taken only while idle
//   cfg_mode            0 OFF, 1 ON, 2 BLINK, 3 CHASE
//   cfg_period_ms       pattern period in ms (0 is stored as 1)
//   cfg_on_ms           BLINK on-time in ms
//   start, stop         run control (start seen only in IDLE, stop only in RUN)
//   busy                high while the pattern runs
//   cycle_done          one-clk pulse after each period wrap
//   led                 registered LED drive, 1 = lit

module led_pattern_ctrl #(
    parameter int N_LED    = 4,
    parameter int TICK_DIV = 50_000,
    parameter int MS_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [MS_W-1:0]  cfg_period_ms,
    input  logic [MS_W-1:0]  cfg_on_ms,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             cycle_done,
    output logic [N_LED-1:0] led
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_CHASE = 2'd3;

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [MS_W-1:0] PERIOD_RST = MS_W'(1000);
    localparam logic [MS_W-1:0] ON_RST     = MS_W'(500);
    localparam logic [N_LED-1:0] CHASE_START = N_LED'(1);

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [MS_W-1:0]   r_period;
    logic [MS_W-1:0]   r_on;
    logic [PW-1:0]     r_presc;
    logic [MS_W-1:0]   r_ms_cnt;
    logic [N_LED-1:0]  r_chase;
    logic              r_cfg_ready;
    logic              r_busy;
    logic              r_cycle_done;
    logic [N_LED-1:0]  r_led;

    logic              w_tick;
    logic              w_wrap;
    logic [MS_W-1:0]   w_ms_next;
    logic [N_LED-1:0]  w_chase_next;
    logic [1:0]        w_entry_mode;
    logic [MS_W-1:0]   w_entry_on;

    // LED image for a given counter state. The led register is loaded from
    // the next-state counter values so the outputs line up with ms_cnt
    // rather than trailing it by one clock.
    function automatic logic [N_LED-1:0] pattern(
        input logic [1:0]       mode,
        input logic [MS_W-1:0]  ms,
        input logic [MS_W-1:0]  on_ms,
        input logic [N_LED-1:0] chase
    );
        logic [N_LED-1:0] v;
        v = '0;
        case (mode)
            MODE_OFF:   v = '0;
            MODE_ON:    v = '1;
            MODE_BLINK: v = (ms < on_ms) ? '1 : '0;
            MODE_CHASE: v = chase;
            default:    v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        w_tick       = (r_presc == TICK_LAST);
        w_wrap       = w_tick && (r_ms_cnt == r_period - 1'b1);
        w_ms_next    = r_ms_cnt;
        if (w_tick) begin
            w_ms_next = w_wrap ? '0 : r_ms_cnt + 1'b1;
        end
        // Rotate-left by one; the top bit returns to bit0.
        w_chase_next = w_wrap ? ((r_chase << 1) | (r_chase >> (N_LED - 1))) : r_chase;
        // A config word arriving with start is the one the run must use.
        w_entry_mode = cfg_valid ? cfg_mode  : r_mode;
        w_entry_on   = cfg_valid ? cfg_on_ms : r_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode       <= MODE_OFF;
            r_period     <= PERIOD_RST;
            r_on         <= ON_RST;
            r_presc      <= '0;
            r_ms_cnt     <= '0;
            r_chase      <= CHASE_START;
            r_cfg_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_cycle_done <= 1'b0;
            r_led        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_led        <= '0;
                    r_busy       <= 1'b0;
                    r_cycle_done <= 1'b0;
                    r_cfg_ready  <= 1'b1;
                    if (cfg_valid) begin
                        r_mode   <= cfg_mode;
                        r_period <= (cfg_period_ms == '0) ? MS_W'(1) : cfg_period_ms;
                        r_on     <= cfg_on_ms;
                    end
                    if (start) begin
                        r_state     <= S_RUN;
                        r_presc     <= '0;
                        r_ms_cnt    <= '0;
                        r_chase     <= CHASE_START;
                        r_busy      <= 1'b1;
                        r_cfg_ready <= 1'b0;
                        r_led       <= pattern(w_entry_mode, '0, w_entry_on, CHASE_START);
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        // Stop wins over a coincident wrap: the partial
                        // period never reports cycle_done.
                        r_state      <= S_IDLE;
                        r_presc      <= '0;
                        r_ms_cnt     <= '0;
                        r_chase      <= CHASE_START;
                        r_cfg_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_cycle_done <= 1'b0;
                        r_led        <= '0;
                    end else begin
                        r_presc      <= w_tick ? '0 : r_presc + 1'b1;
                        r_ms_cnt     <= w_ms_next;
                        r_chase      <= w_chase_next;
                        r_cycle_done <= w_wrap;
                        r_led        <= pattern(r_mode, w_ms_next, r_on, w_chase_next);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign busy       = r_busy;
    assign cycle_done = r_cycle_done;
    assign led        = r_led;

endmodule
